// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch stage sitting directly in front of the IF/ID latch. It
// owns the program counter, issues the instruction-memory read, and presents
// pc / pc+4 / next-pc / fetched word to IF/ID with a qualified capture strobe
// and a flush request. Redirects (branch/jump) and halt coming from later
// stages are handled even while an imem access is still outstanding.
//
// Parameters
//   PC_INIT       reset value of the program counter (low 2 bits cleared)
//
// Ports
//   CLK           system clock, rising edge
//   nRST          asynchronous active-low reset
//   ihit          imem response valid this cycle
//   imemload      instruction word returned by imem
//   imemREN       imem read request
//   imemaddr      imem read address (always the current pc)
//   freeze        hazard-unit stall, IF/ID not accepting
//   redirect      later stage requests a PC change
//   redirect_pc   redirect target (low 2 bits ignored)
//   halt          halt instruction resolved downstream
//   pc_o          address of the fetched word
//   pc_p4_o       pc_o + 4 (wraps modulo 2^32)
//   nxt_pc_o      pc value after the next rising edge
//   imem_load_o   fetched word, passed straight through from imemload
//   fetch_valid   IF/ID should capture this cycle
//   flush_o       IF/ID must flush its contents
//
// Optional build macro
//   FETCH_PERF_EN adds fetch_count / bubble_count performance counters.
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        freeze,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic [31:0] pc_o,
    output logic [31:0] pc_p4_o,
    output logic [31:0] nxt_pc_o,
    output logic [31:0] imem_load_o,
    output logic        fetch_valid,
    output logic        flush_o
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] bubble_count
`endif
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        REDIR_WAIT = 2'd1,
        DRAIN      = 2'd2,
        HALTED     = 2'd3
    } state_t;

    localparam logic [31:0] PC_RESET = PC_INIT & ~32'h3;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] tgt_q, tgt_d;

    logic [31:0] pc_p4;
    logic [31:0] redir_tgt;
    logic        fetch_valid_raw;
    logic        flush_raw;

    // Word alignment is enforced here so nothing downstream ever sees an
    // unaligned target.
    assign redir_tgt = redirect_pc & ~32'h3;
    assign pc_p4     = pc_q + 32'd4;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= RUN;
            pc_q    <= PC_RESET;
            tgt_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;

        unique case (state_q)
            RUN: begin
                if (halt) begin
                    state_d = ihit ? HALTED : DRAIN;
                end else if (redirect) begin
                    if (ihit) begin
                        pc_d = redir_tgt;
                    end else begin
                        // The access in flight cannot be cancelled; park the
                        // target until its (stale) response comes back.
                        tgt_d   = redir_tgt;
                        state_d = REDIR_WAIT;
                    end
                end else if (ihit && !freeze) begin
                    pc_d = pc_p4;
                end
            end

            REDIR_WAIT: begin
                if (halt) begin
                    state_d = ihit ? HALTED : DRAIN;
                end else begin
                    // Newest redirect wins, including one arriving together
                    // with the hit that retires the stale access.
                    if (redirect) begin
                        tgt_d = redir_tgt;
                    end
                    if (ihit) begin
                        pc_d    = redirect ? redir_tgt : tgt_q;
                        state_d = RUN;
                    end
                end
            end

            DRAIN: begin
                if (ihit) begin
                    state_d = HALTED;
                end
            end

            HALTED: begin
                state_d = HALTED;
            end

            default: begin
                state_d = RUN;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic
    // -------------------------------------------------------------------------
    always_comb begin
        imemREN         = 1'b1;
        fetch_valid_raw = 1'b0;
        flush_raw       = 1'b0;

        unique case (state_q)
            RUN: begin
                if (!halt) begin
                    if (redirect) begin
                        flush_raw = 1'b1;
                    end else begin
                        fetch_valid_raw = ihit && !freeze;
                    end
                end
            end

            REDIR_WAIT: begin
                flush_raw = !halt && redirect;
            end

            DRAIN: begin
                imemREN = 1'b1;
            end

            HALTED: begin
                imemREN = 1'b0;
            end

            default: begin
                imemREN = 1'b1;
            end
        endcase
    end

    // While nRST is held low the register outputs already sit at their reset
    // values, but the strobes are combinational from live inputs and must be
    // forced quiet as well.
    assign fetch_valid = fetch_valid_raw && nRST;
    assign flush_o     = flush_raw && nRST;

    assign imemaddr    = pc_q;
    assign pc_o        = pc_q;
    assign pc_p4_o     = pc_p4;
    assign nxt_pc_o    = pc_d;
    assign imem_load_o = imemload;

`ifdef FETCH_PERF_EN
    // -------------------------------------------------------------------------
    // Performance counters
    // -------------------------------------------------------------------------
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;
    logic        active_state;

    assign active_state = (state_q == RUN) || (state_q == REDIR_WAIT);

    always_comb begin
        fetch_cnt_d  = fetch_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (fetch_valid) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if (active_state && !fetch_valid) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            fetch_cnt_q  <= 32'h0;
            bubble_cnt_q <= 32'h0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign fetch_count  = fetch_cnt_q;
    assign bubble_count = bubble_cnt_q;
`endif

endmodule
